// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel double-buffered PWM generator
//
// Purpose: CH PWM channels sharing one N-bit counter with a runtime period,
// edge- or centre-aligned counting, and duty registers that are written into
// a shadow copy and only become active at a period boundary (cnt==0).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous reset, active-high
//   enable       1 = run, 0 = counter held at 0 and outputs low
//   center       0 = edge-aligned, 1 = centre-aligned (taken at boundary)
//   period       period value P (taken at boundary)
//   wr_en        duty shadow write strobe
//   wr_addr      channel index for the write (indices >= CH ignored)
//   wr_data      duty value
//   pwm_out      registered PWM outputs, bit i = channel i
//   cycle_start  registered one-clock pulse at the start of each period
module pwm_multi #(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          center,
  input  logic [N-1:0]  period,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  output logic [CH-1:0] pwm_out,
  output logic          cycle_start
);

  logic [N-1:0]  cnt_q, cnt_d;
  logic          dir_down_q, dir_down_d;
  logic [N-1:0]  period_act_q;
  logic          center_act_q;
  logic [N-1:0]  duty_shadow_q [CH];
  logic [N-1:0]  duty_act_q    [CH];
  logic [CH-1:0] pwm_q, pwm_d;
  logic          cs_q, cs_d;

  logic          boundary;
  logic [N-1:0]  period_eff;
  logic          center_eff;
  logic          down_eff;

  // In a boundary cycle the freshly sampled settings are used directly, so
  // the first count and compares of a new period already see them.
  always_comb begin
    boundary   = enable && (cnt_q == '0);
    period_eff = boundary ? period : period_act_q;
    center_eff = boundary ? center : center_act_q;
    down_eff   = boundary ? 1'b0 : dir_down_q;

    cnt_d      = '0;
    dir_down_d = 1'b0;
    pwm_d      = '0;
    cs_d       = 1'b0;

    if (enable) begin
      cs_d = boundary;
      for (int i = 0; i < CH; i++) begin
        pwm_d[i] = cnt_q < (boundary ? duty_shadow_q[i] : duty_act_q[i]);
      end

      if (!center_eff) begin
        // Edge-aligned: 0..P then wrap.
        cnt_d = (cnt_q >= period_eff) ? '0 : cnt_q + 1'b1;
      end else if (period_eff == '0) begin
        cnt_d = '0;
      end else if (!down_eff) begin
        // Centre-aligned rising half; turn around at P.
        if (cnt_q >= period_eff) begin
          dir_down_d = 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end else begin
          cnt_d      = cnt_q + 1'b1;
        end
      end else begin
        // Falling half; direction returns to up as the count reaches 0.
        dir_down_d = (cnt_q > 1);
        cnt_d      = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      dir_down_q   <= 1'b0;
      period_act_q <= '0;
      center_act_q <= 1'b0;
      pwm_q        <= '0;
      cs_q         <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty_shadow_q[i] <= '0;
        duty_act_q[i]    <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      pwm_q      <= pwm_d;
      cs_q       <= cs_d;
      if (boundary) begin
        period_act_q <= period;
        center_act_q <= center;
        for (int i = 0; i < CH; i++) begin
          duty_act_q[i] <= duty_shadow_q[i];
        end
      end
      // Address match per channel; addresses with no channel match nothing.
      for (int i = 0; i < CH; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          duty_shadow_q[i] <= wr_data;
        end
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign cycle_start = cs_q;

endmodule
